// File: rtl/tdc_pulse_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tdc_pulse_gen
// Brief    : TDC calibration burst: start/stop pair D cycles apart, settle gap,
//            sample and accumulate the sensor count per interval.
// Revision : 1.0  initial release
// ============================================================================
module tdc_pulse_gen #(
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        abort,
  input  logic [7:0]  cfg_delay,
  input  logic [7:0]  cfg_count,
  input  logic [7:0]  tdc_value,
  output logic        start_o,
  output logic        stop_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] sum_o
);

  localparam logic [7:0] c_GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_dly;
  logic [7:0]  w_dly_nxt;
  logic [7:0]  r_rem;
  logic [7:0]  w_rem_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [15:0] r_sum;
  logic [15:0] w_sum_nxt;
  logic        r_start;
  logic        r_stop;
  logic        r_busy;
  logic        r_done;
  logic        w_start_nxt;
  logic        w_stop_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;

  // r_cnt serves both as the start-to-stop down-counter and the gap counter.
  always_comb begin
    w_state_nxt = r_state;
    w_dly_nxt   = r_dly;
    w_rem_nxt   = r_rem;
    w_cnt_nxt   = r_cnt;
    w_sum_nxt   = r_sum;
    w_done_nxt  = 1'b0;

    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (go && !abort) begin
            w_dly_nxt   = cfg_delay;
            w_rem_nxt   = cfg_count;
            w_sum_nxt   = 16'd0;
            w_state_nxt = S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (r_dly == 8'd0) begin
            w_cnt_nxt   = c_GAP_LAST;
            w_state_nxt = S_GAP;
          end else begin
            w_cnt_nxt   = r_dly - 8'd1;
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 8'd0) begin
            w_cnt_nxt   = c_GAP_LAST;
            w_state_nxt = S_GAP;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == 8'd0) begin
            w_sum_nxt = r_sum + {8'd0, tdc_value};
            if (r_rem != 8'd0) begin
              w_rem_nxt   = r_rem - 8'd1;
              w_state_nxt = S_LAUNCH;
            end else begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Pulses are decoded from the upcoming state so they leave a flop aligned
  // with the state they belong to.
  always_comb begin
    w_start_nxt = (w_state_nxt == S_LAUNCH);
    w_stop_nxt  = ((w_state_nxt == S_LAUNCH) && (w_dly_nxt == 8'd0)) ||
                  ((w_state_nxt == S_WAIT) && (w_cnt_nxt == 8'd0));
    w_busy_nxt  = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dly   <= 8'd0;
      r_rem   <= 8'd0;
      r_cnt   <= 8'd0;
      r_sum   <= 16'd0;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dly   <= w_dly_nxt;
      r_rem   <= w_rem_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sum   <= w_sum_nxt;
      r_start <= w_start_nxt;
      r_stop  <= w_stop_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign start_o = r_start;
  assign stop_o  = r_stop;
  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign sum_o   = r_sum;

endmodule
`default_nettype wire
